// File: rtl/feeder_pkg.sv
// Shared definitions for the serial bit feeder: FSM state encodings and
// default parameter values.
package feeder_pkg;

  typedef enum logic [1:0] {
    FEED_IDLE  = 2'b00,
    FEED_SHIFT = 2'b01,
    FEED_GAP   = 2'b10
  } feed_state_e;

  localparam int unsigned DefWidth     = 8;
  localparam int unsigned DefGapCycles = 2;
  localparam bit          DefMsbFirst  = 1'b1;
  localparam bit          DefIdleBit   = 1'b0;

endpackage

// File: rtl/feeder_shift_reg.sv
// Parallel-load shift register with bit counter; flags the final bit of a word.
module feeder_shift_reg #(
  parameter int unsigned WIDTH     = feeder_pkg::DefWidth,
  parameter bit          MSB_FIRST = feeder_pkg::DefMsbFirst
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic             bit_out,
  output logic             last
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [WIDTH-1:0] sreg_q;
  logic [CntW-1:0]  cnt_q;

  // Load wins over shift so a back-to-back word replaces the spent one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      sreg_q <= load_data;
      cnt_q  <= '0;
    end else if (shift) begin
      if (MSB_FIRST) sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
      else           sreg_q <= {1'b0, sreg_q[WIDTH-1:1]};
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bit_out = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
  assign last    = (cnt_q == CntW'(WIDTH - 1));

endmodule

// File: rtl/serial_bit_feeder.sv
// Double-buffered parallel-to-serial source with a programmable inter-word idle
// gap, feeding the single-bit sequence FSM.
module serial_bit_feeder
  import feeder_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned GAP_CYCLES = DefGapCycles,
  parameter bit          MSB_FIRST  = DefMsbFirst,
  parameter bit          IDLE_BIT   = DefIdleBit
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             last,
  output logic             busy
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  feed_state_e      state_q, state_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;

  logic             sr_load;
  logic [WIDTH-1:0] sr_data;
  logic             sr_bit;
  logic             sr_last;
  logic             accept;
  logic             shift_last;
  logic             gap_last;
  logic             shifter_free;

  assign accept     = load && !buf_full_q;
  assign shift_last = (state_q == FEED_SHIFT) && sr_last;
  assign gap_last   = (state_q == FEED_GAP) && ((32'(gap_cnt_q) + 32'd1) == GAP_CYCLES);
  assign shifter_free = (state_q == FEED_IDLE) || (shift_last && (GAP_CYCLES == 0)) || gap_last;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    gap_cnt_d  = gap_cnt_q;
    sr_load    = 1'b0;
    sr_data    = data_in;

    // Buffered word is always older than one arriving now, so it goes first.
    if (shifter_free && buf_full_q) begin
      sr_load    = 1'b1;
      sr_data    = buf_q;
      buf_full_d = accept;
      if (accept) buf_d = data_in;
    end else if (shifter_free && accept) begin
      sr_load = 1'b1;
    end else if (accept) begin
      buf_d      = data_in;
      buf_full_d = 1'b1;
    end

    case (state_q)
      FEED_IDLE: begin
        if (sr_load) state_d = FEED_SHIFT;
      end
      FEED_SHIFT: begin
        if (sr_last) begin
          if (GAP_CYCLES > 0) begin
            state_d   = FEED_GAP;
            gap_cnt_d = '0;
          end else begin
            state_d = sr_load ? FEED_SHIFT : FEED_IDLE;
          end
        end
      end
      FEED_GAP: begin
        if (gap_last) state_d = sr_load ? FEED_SHIFT : FEED_IDLE;
        else          gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = FEED_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= FEED_IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  feeder_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clock     (clock),
    .reset     (reset),
    .load      (sr_load),
    .load_data (sr_data),
    .shift     (state_q == FEED_SHIFT),
    .bit_out   (sr_bit),
    .last      (sr_last)
  );

  assign ready   = !buf_full_q;
  assign x_valid = (state_q == FEED_SHIFT);
  assign x_out   = x_valid ? sr_bit : IDLE_BIT;
  assign last    = x_valid && sr_last;
  assign busy    = (state_q != FEED_IDLE) || buf_full_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: default, zero-gap and LSB-first instances.
module tb_serial_bit_feeder;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Instance A: WIDTH=8, GAP_CYCLES=2, MSB first
  logic [7:0] d_a = '0;
  logic       ld_a = 1'b0;
  logic       rdy_a, xo_a, xv_a, last_a, busy_a;
  // Instance Z: GAP_CYCLES=0
  logic [7:0] d_z = '0;
  logic       ld_z = 1'b0;
  logic       rdy_z, xo_z, xv_z, last_z, busy_z;
  // Instance L: MSB_FIRST=0
  logic [7:0] d_l = '0;
  logic       ld_l = 1'b0;
  logic       rdy_l, xo_l, xv_l, last_l, busy_l;

  serial_bit_feeder #(.WIDTH(8), .GAP_CYCLES(2), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
    .clock(clock), .reset(reset), .data_in(d_a), .load(ld_a), .ready(rdy_a),
    .x_out(xo_a), .x_valid(xv_a), .last(last_a), .busy(busy_a)
  );
  serial_bit_feeder #(.WIDTH(8), .GAP_CYCLES(0), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_z (
    .clock(clock), .reset(reset), .data_in(d_z), .load(ld_z), .ready(rdy_z),
    .x_out(xo_z), .x_valid(xv_z), .last(last_z), .busy(busy_z)
  );
  serial_bit_feeder #(.WIDTH(8), .GAP_CYCLES(2), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clock(clock), .reset(reset), .data_in(d_l), .load(ld_l), .ready(rdy_l),
    .x_out(xo_l), .x_valid(xv_l), .last(last_l), .busy(busy_l)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({xo_a, xv_a, last_a, rdy_a, busy_a} !== 5'b00010) begin
      errors++;
      $display("FAIL reset_a got %b want 00010", {xo_a, xv_a, last_a, rdy_a, busy_a});
    end
    checks++;
    if ({xv_z, rdy_z, busy_z, xv_l, rdy_l, busy_l} !== 6'b010010) begin
      errors++;
      $display("FAIL reset_zl got %b want 010010", {xv_z, rdy_z, busy_z, xv_l, rdy_l, busy_l});
    end
    reset = 1'b1;
    tick();
  endtask

  // A5 MSB first: 1,0,1,0,0,1,0,1 then two gap cycles, then idle.
  task automatic test_single_word();
    logic [7:0] exp_bits = 8'b1010_0101;
    d_a = 8'hA5; ld_a = 1'b1;
    tick();
    ld_a = 1'b0; d_a = 8'h00;
    for (int j = 0; j < 11; j++) begin
      checks++;
      if (j < 8) begin
        if ({xv_a, xo_a, last_a} !== {1'b1, exp_bits[7-j], (j == 7)}) begin
          errors++;
          $display("FAIL single_bit%0d got v/x/l=%b want %b", j, {xv_a, xo_a, last_a},
                   {1'b1, exp_bits[7-j], (j == 7)});
        end
      end else if ({xv_a, xo_a, last_a} !== 3'b000) begin
        errors++;
        $display("FAIL single_idle%0d got v/x/l=%b want 000", j, {xv_a, xo_a, last_a});
      end
      if (j == 9 || j == 10) begin
        checks++;
        if (busy_a !== (j == 9)) begin
          errors++;
          $display("FAIL single_busy%0d got %b want %b", j, busy_a, (j == 9));
        end
      end
      tick();
    end
  endtask

  // F0 then 0F two cycles later; optionally offer 55 while the buffer is full.
  task automatic test_buffered(input bit try_drop);
    logic [7:0] w0 = 8'hF0;
    logic [7:0] w1 = 8'h0F;
    logic       ev, eb, el, er;
    d_a = 8'hF0; ld_a = 1'b1;
    tick();
    ld_a = 1'b0;
    for (int j = 0; j < 22; j++) begin
      ev = 1'b0; eb = 1'b0; el = 1'b0;
      if (j < 8) begin
        ev = 1'b1; eb = w0[7-j]; el = (j == 7);
      end else if (j >= 10 && j < 18) begin
        ev = 1'b1; eb = w1[17-j]; el = (j == 17);
      end
      er = !(j >= 2 && j < 10);
      checks++;
      if ({xv_a, xo_a, last_a} !== {ev, eb, el}) begin
        errors++;
        $display("FAIL buffered%0d_c%0d got v/x/l=%b want %b", try_drop, j,
                 {xv_a, xo_a, last_a}, {ev, eb, el});
      end
      checks++;
      if (rdy_a !== er) begin
        errors++;
        $display("FAIL buffered%0d_ready_c%0d got %b want %b", try_drop, j, rdy_a, er);
      end
      ld_a = 1'b0;
      if (j == 1) begin
        d_a = 8'h0F; ld_a = 1'b1;
      end
      if (try_drop && j == 4) begin
        d_a = 8'h55; ld_a = 1'b1;
      end
      tick();
    end
    ld_a = 1'b0;
  endtask

  // GAP_CYCLES=0: FF then 00 gives 16 contiguous valid cycles.
  task automatic test_back_to_back();
    d_z = 8'hFF; ld_z = 1'b1;
    tick();
    ld_z = 1'b0;
    for (int j = 0; j < 18; j++) begin
      checks++;
      if (j < 16) begin
        if ({xv_z, xo_z, last_z} !== {1'b1, (j < 8), (j == 7 || j == 15)}) begin
          errors++;
          $display("FAIL b2b_c%0d got v/x/l=%b want %b", j, {xv_z, xo_z, last_z},
                   {1'b1, (j < 8), (j == 7 || j == 15)});
        end
      end else if ({xv_z, xo_z, last_z, busy_z} !== 4'b0000) begin
        errors++;
        $display("FAIL b2b_idle_c%0d got v/x/l/b=%b want 0000", j, {xv_z, xo_z, last_z, busy_z});
      end
      ld_z = 1'b0;
      if (j == 2) begin
        d_z = 8'h00; ld_z = 1'b1;
      end
      tick();
    end
  endtask

  // LSB first, 01: x_out 1 then seven 0s.
  task automatic test_lsb_first();
    d_l = 8'h01; ld_l = 1'b1;
    tick();
    ld_l = 1'b0;
    for (int j = 0; j < 9; j++) begin
      checks++;
      if (j < 8) begin
        if ({xv_l, xo_l, last_l} !== {1'b1, (j == 0), (j == 7)}) begin
          errors++;
          $display("FAIL lsb_c%0d got v/x/l=%b want %b", j, {xv_l, xo_l, last_l},
                   {1'b1, (j == 0), (j == 7)});
        end
      end else if (xv_l !== 1'b0) begin
        errors++;
        $display("FAIL lsb_end got valid=%b want 0", xv_l);
      end
      tick();
    end
  endtask

  // Reset after the 4th bit with a second word buffered: everything discarded.
  task automatic test_reset_mid_word();
    logic [7:0] exp_bits = 8'hA5;
    d_a = 8'hA5; ld_a = 1'b1;
    tick();
    d_a = 8'h3C;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if ({xv_a, xo_a} !== {1'b1, exp_bits[7-j]}) begin
        errors++;
        $display("FAIL rst_pre_c%0d got v/x=%b want %b", j, {xv_a, xo_a}, {1'b1, exp_bits[7-j]});
      end
      tick();
      ld_a = 1'b0;
    end
    checks++;
    if (rdy_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre_ready got %b want 0", rdy_a);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({xv_a, xo_a, last_a, rdy_a, busy_a} !== 5'b00010) begin
      errors++;
      $display("FAIL rst_async got v/x/l/r/b=%b want 00010", {xv_a, xo_a, last_a, rdy_a, busy_a});
    end
    tick();
    reset = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick();
      checks++;
      if ({xv_a, xo_a, rdy_a, busy_a} !== 4'b0010) begin
        errors++;
        $display("FAIL rst_after_c%0d got v/x/r/b=%b want 0010", j, {xv_a, xo_a, rdy_a, busy_a});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_buffered(1'b0);
    test_buffered(1'b1);
    test_back_to_back();
    test_lsb_first();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
